// File: rtl/w0rm_wb_pkg.sv
// Shared constants, the FIFO entry layout and the slot helper for the ALU writeback stage.
package w0rm_wb_pkg;

    localparam int WB_ADDR_W   = 4;
    localparam int WB_DATA_W   = 8;
    localparam int WB_DST_LSB  = 0;
    localparam int WB_WE_BIT   = WB_ADDR_W;
    localparam int WB_MIN_FREE = 2;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // The write-enable flag sits directly above the destination index in user_data.
    function automatic int wb_we_bit(input int addr_w);
        return WB_DST_LSB + addr_w;
    endfunction

    function automatic int unsigned wb_free_slots(input int unsigned depth, input int unsigned count);
        return depth - count;
    endfunction

endpackage

// File: rtl/w0rm_wb_fifo.sv
// Synchronous FIFO with flush, occupancy outputs and a parallel per-slot view
// so the owner can search all buffered entries combinationally.
module w0rm_wb_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            slot_valid,
    output logic [DEPTH-1:0][WIDTH-1:0] slot_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data   = mem[rd_ptr];
    assign slot_data = mem;

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_valid[i] = ({1'b0, PW'(PW'(i) - rd_ptr)} < count);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/w0rm_alu_writeback.sv
// Retires ALU results into the shared RF write port through a small FIFO.
// Define W0RM_WB_BYPASS_EN to let a result skip an empty FIFO when the port is free.
module w0rm_alu_writeback
    import w0rm_wb_pkg::*;
#(
    parameter int DATA_WIDTH     = WB_DATA_W,
    parameter int REG_ADDR_WIDTH = WB_ADDR_W,
    parameter int USER_WIDTH     = REG_ADDR_WIDTH + 1,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     result,
    input  logic                      result_valid,
    input  logic [USER_WIDTH-1:0]     user_data,
    output logic                      mem_ready,
    input  logic                      rf_port_busy,
    output logic                      rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0]     rf_wr_data,
    input  logic [REG_ADDR_WIDTH-1:0] query_addr,
    output logic                      hazard,
    output logic                      overflow
);

    localparam int EW     = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int WE_BIT = wb_we_bit(REG_ADDR_WIDTH);

    logic                      we;
    logic [REG_ADDR_WIDTH-1:0] dst;
    logic                      qualify;
    logic                      bypass;
    logic                      push;
    logic                      pop;
    logic [EW-1:0]             head;
    logic [CW-1:0]             count;
    logic                      full;
    logic                      empty;
    logic [DEPTH-1:0]          slot_valid;
    logic [DEPTH-1:0][EW-1:0]  slot_data;

    assign we      = user_data[WE_BIT];
    assign dst     = user_data[WB_DST_LSB +: REG_ADDR_WIDTH];
    assign qualify = result_valid && we && !flush;
    assign pop     = !empty && !rf_port_busy && !flush;

`ifdef W0RM_WB_BYPASS_EN
    assign bypass = qualify && empty && !rf_port_busy;
`else
    assign bypass = 1'b0;
`endif

    assign push = qualify && !bypass;

    // Two free slots are needed because one ALU result may already be in flight.
    assign mem_ready = (wb_free_slots(DEPTH, 32'(count)) >= WB_MIN_FREE);

    w0rm_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push),
        .wr_data    ({dst, result}),
        .pop        (pop),
        .rd_data    (head),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .slot_valid (slot_valid),
        .slot_data  (slot_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else if (flush) begin
            rf_wr_en <= 1'b0;
        end else if (pop) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= head[DATA_WIDTH +: REG_ADDR_WIDTH];
            rf_wr_data <= head[DATA_WIDTH-1:0];
        end else if (bypass) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= dst;
            rf_wr_data <= result;
        end else begin
            rf_wr_en <= 1'b0;
        end
    end

    // Dropped results are remembered until reset; flush deliberately leaves this alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && full) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        hazard = rf_wr_en && (rf_wr_addr == query_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (slot_data[i][DATA_WIDTH +: REG_ADDR_WIDTH] == query_addr)) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_w0rm_alu_writeback.sv
// Directed testbench for w0rm_alu_writeback; expected RF latency follows W0RM_WB_BYPASS_EN.
module tb_w0rm_alu_writeback;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int UW    = AW + 1;
    localparam int DEPTH = 4;
`ifdef W0RM_WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] result;
    logic          result_valid;
    logic [UW-1:0] user_data;
    logic          mem_ready;
    logic          rf_port_busy;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic [AW-1:0] query_addr;
    logic          hazard;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+DW-1:0] exp_q[$];

    w0rm_alu_writeback #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .USER_WIDTH     (UW),
        .DEPTH          (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .result       (result),
        .result_valid (result_valid),
        .user_data    (user_data),
        .mem_ready    (mem_ready),
        .rf_port_busy (rf_port_busy),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .query_addr   (query_addr),
        .hazard       (hazard),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        result_valid = v;
        user_data    = {we, a};
        result       = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; rf_port_busy = 1'b0; query_addr = '0;
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", rf_wr_en); end
        n_checks++; if (rf_wr_addr !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", rf_wr_addr); end
        n_checks++; if (rf_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rf_wr_data); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready: got %b expected 1", mem_ready); end
        rst_n = 1'b1;
        step();
        n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_release_en: got %b expected 0", rf_wr_en); end
    endtask

    task automatic test_single();
        logic exp_en;
        query_addr = 4'h3;
        drive(1'b1, 1'b1, 4'h3, 8'h5A);
        step();
        drive(1'b0, 1'b0, '0, '0);
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k > 1) step();
            exp_en = (k == LAT);
            n_checks++; if (rf_wr_en !== exp_en) begin n_fail++; $display("FAIL single_en k=%0d: got %b expected %b", k, rf_wr_en, exp_en); end
            if (k == LAT) begin
                n_checks++; if (rf_wr_addr !== 4'h3) begin n_fail++; $display("FAIL single_addr: got %h expected 3", rf_wr_addr); end
                n_checks++; if (rf_wr_data !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h expected 5a", rf_wr_data); end
            end
            n_checks++; if (hazard !== (k <= LAT)) begin n_fail++; $display("FAIL single_hazard k=%0d: got %b expected %b", k, hazard, (k <= LAT)); end
        end
    endtask

    task automatic test_we_zero();
        query_addr = 4'h7;
        drive(1'b1, 1'b0, 4'h7, 8'hFF);
        step();
        drive(1'b0, 1'b0, '0, '0);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) step();
            n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL we_zero_en k=%0d: got %b expected 0", k, rf_wr_en); end
            n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL we_zero_hazard k=%0d: got %b expected 0", k, hazard); end
            n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL we_zero_mem_ready k=%0d: got %b expected 1", k, mem_ready); end
        end
    endtask

    task automatic test_throughput();
        logic [DW-1:0] dv [3] = '{8'h91, 8'hA2, 8'hB3};
        logic exp_en;
        int j;
        rf_port_busy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive(1'b1, 1'b1, AW'(9 + c), dv[c]);
            else drive(1'b0, 1'b0, '0, '0);
            step();
            j = c - (LAT - 1);
            exp_en = (j >= 0 && j < 3);
            n_checks++; if (rf_wr_en !== exp_en) begin n_fail++; $display("FAIL thru_en c=%0d: got %b expected %b", c, rf_wr_en, exp_en); end
            if (exp_en) begin
                n_checks++; if ({rf_wr_addr, rf_wr_data} !== {AW'(9 + j), dv[j]}) begin n_fail++; $display("FAIL thru_write c=%0d: got %h expected %h", c, {rf_wr_addr, rf_wr_data}, {AW'(9 + j), dv[j]}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        rf_port_busy = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            d = DW'(17 * (i + 1));
            drive(1'b1, 1'b1, AW'(i + 1), d);
            exp_q.push_back({AW'(i + 1), d});
            step();
            n_checks++; if (mem_ready !== (i < 2)) begin n_fail++; $display("FAIL b2b_mem_ready i=%0d: got %b expected %b", i, mem_ready, (i < 2)); end
            n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_blocked_en i=%0d: got %b expected 0", i, rf_wr_en); end
        end
        drive(1'b0, 1'b0, '0, '0);
        query_addr = 4'h2;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_en i=%0d: got %b expected 0", i, rf_wr_en); end
            n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL b2b_hazard i=%0d: got %b expected 1", i, hazard); end
        end
        rf_port_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [AW+DW-1:0] e;
            step();
            e = exp_q.pop_front();
            n_checks++; if (rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL b2b_drain_en i=%0d: got %b expected 1", i, rf_wr_en); end
            n_checks++; if ({rf_wr_addr, rf_wr_data} !== e) begin n_fail++; $display("FAIL b2b_drain_write i=%0d: got %h expected %h", i, {rf_wr_addr, rf_wr_data}, e); end
        end
        step();
        n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_en: got %b expected 0", rf_wr_en); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_mem_ready_idle: got %b expected 1", mem_ready); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] d;
        rf_port_busy = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            d = DW'(8'hA0 + i);
            drive(1'b1, 1'b1, AW'(5 + i), d);
            if (i < 4) exp_q.push_back({AW'(5 + i), d});
            step();
            n_checks++; if (overflow !== (i == 4)) begin n_fail++; $display("FAIL ovf_flag i=%0d: got %b expected %b", i, overflow, (i == 4)); end
        end
        drive(1'b0, 1'b0, '0, '0);
        rf_port_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [AW+DW-1:0] e;
            step();
            e = exp_q.pop_front();
            n_checks++; if (rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_en i=%0d: got %b expected 1", i, rf_wr_en); end
            n_checks++; if ({rf_wr_addr, rf_wr_data} !== e) begin n_fail++; $display("FAIL ovf_drain_write i=%0d: got %h expected %h", i, {rf_wr_addr, rf_wr_data}, e); end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL ovf_extra_write i=%0d: got %b expected 0", i, rf_wr_en); end
            n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky i=%0d: got %b expected 1", i, overflow); end
        end
    endtask

    task automatic test_flush();
        rf_port_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, AW'(1 + i), DW'(8'hC1 + i));
            step();
        end
        query_addr = 4'h1;
        #1;
        n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL flush_pre_hazard: got %b expected 1", hazard); end
        flush = 1'b1;
        rf_port_busy = 1'b0;
        drive(1'b1, 1'b1, 4'h4, 8'hC4);
        step();
        flush = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL flush_en: got %b expected 0", rf_wr_en); end
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_r1: got %b expected 0", hazard); end
        query_addr = 4'h4;
        #1;
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_r4: got %b expected 0", hazard); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL flush_mem_ready: got %b expected 1", mem_ready); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL flush_overflow_kept: got %b expected 1", overflow); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL flush_late_write i=%0d: got %b expected 0", i, rf_wr_en); end
        end
    endtask

    task automatic test_async_reset();
        rf_port_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, AW'(13 + i), DW'(8'hD1 + 17 * i));
            step();
        end
        drive(1'b0, 1'b0, '0, '0);
        rf_port_busy = 1'b0;
        step();
        n_checks++; if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 4'hD, 8'hD1}) begin n_fail++; $display("FAIL areset_pre_write: got %h expected %h", {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 4'hD, 8'hD1}); end
        query_addr = 4'hE;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL areset_en: got %b expected 0", rf_wr_en); end
        n_checks++; if (rf_wr_addr !== 4'h0) begin n_fail++; $display("FAIL areset_addr: got %h expected 0", rf_wr_addr); end
        n_checks++; if (rf_wr_data !== 8'h00) begin n_fail++; $display("FAIL areset_data: got %h expected 00", rf_wr_data); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL areset_overflow: got %b expected 0", overflow); end
        n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL areset_hazard: got %b expected 0", hazard); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL areset_mem_ready: got %b expected 1", mem_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL areset_late_write i=%0d: got %b expected 0", i, rf_wr_en); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_we_zero();
        test_throughput();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
